// File: rtl/fetch_stage_pkg.sv
// -----------------------------------------------------------------------------
// fetch_stage_pkg
// Shared CPU definitions for the instruction-fetch stage.
//   fetch_state_t : fetch FSM encoding (IDLE / REQ / HOLD / DRAIN)
//   NOP_INSTR     : instruction word shown to the decoder when IF/ID is empty
//   PC_INC        : sequential PC step (one 32-bit word)
//   IF_ID_W       : width of the {instruct, if_pc, if_valid} pipeline bundle
//   SKID_W        : width of a parked response {instruction, pc+4}
//   if_id_t       : packed IF/ID pipeline register layout (IF_ID_W bits)
//   pc_plus_inc   : sequential next-PC, wraps modulo 2^32
//   align_word    : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package fetch_stage_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,   // one cycle after reset before fetching starts
      REQ   = 2'd1,   // request driven at the current pc
      HOLD  = 2'd2,   // a response is parked in the skid buffer
      DRAIN = 2'd3    // a killed request is still waiting for its ack
   } fetch_state_t;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_INC    = 32'd4;
   localparam int          IF_ID_W   = 65;
   localparam int          SKID_W    = 64;

   // IF/ID bundle; field order matches {instruct, if_pc, if_valid}
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        valid;
   } if_id_t;

   function automatic logic [31:0] pc_plus_inc(input logic [31:0] pc);
      return pc + PC_INC;
   endfunction

   function automatic logic [31:0] align_word(input logic [31:0] addr);
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// -----------------------------------------------------------------------------
// fetch_stage_if
// Bundles the fetch stage's handshake and pipeline signals.
//   Control in   : stall, redir_en, redir_pc
//   Memory       : imem_req, imem_addr (out of fetch), imem_ack, imem_rdata (in)
//   IF/ID output : instruct, if_pc, if_valid
// Modports:
//   master - the fetch stage itself
//   slave  - the surroundings (memory, decoder, execute redirect)
// -----------------------------------------------------------------------------
interface fetch_stage_if;

   logic        stall;
   logic        redir_en;
   logic [31:0] redir_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic [31:0] instruct;
   logic [31:0] if_pc;
   logic        if_valid;

   modport master (
      input  stall,
      input  redir_en,
      input  redir_pc,
      output imem_req,
      output imem_addr,
      input  imem_ack,
      input  imem_rdata,
      output instruct,
      output if_pc,
      output if_valid
   );

   modport slave (
      output stall,
      output redir_en,
      output redir_pc,
      input  imem_req,
      input  imem_addr,
      output imem_ack,
      output imem_rdata,
      input  instruct,
      input  if_pc,
      input  if_valid
   );

endinterface

// File: rtl/fetch_skid_buf.sv
// -----------------------------------------------------------------------------
// fetch_skid_buf
// One-entry buffer that parks a memory response arriving while the decoder
// is stalled, so the request slot can be retired without losing the word.
// Ports:
//   clk       in   rising-edge clock
//   clr_n     in   asynchronous active-low reset
//   i_load    in   capture i_data (response accepted during a stall)
//   i_release in   entry handed to IF/ID this cycle
//   i_clear   in   discard entry (redirect); wins over load/release
//   i_data    in   {instruction, pc+4}
//   o_data    out  parked {instruction, pc+4}
//   o_valid   out  entry is occupied
// -----------------------------------------------------------------------------
module fetch_skid_buf
   import fetch_stage_pkg::*;
(
   input  logic              clk,
   input  logic              clr_n,
   input  logic              i_load,
   input  logic              i_release,
   input  logic              i_clear,
   input  logic [SKID_W-1:0] i_data,
   output logic [SKID_W-1:0] o_data,
   output logic              o_valid
);

   logic [SKID_W-1:0] r_data;
   logic              r_valid;

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_clear) begin
         r_data  <= '0;
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_data  <= i_data;
         r_valid <= 1'b1;
      end else if (i_release) begin
         r_valid <= 1'b0;
      end
   end

   assign o_data  = r_data;
   assign o_valid = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: owns the PC, issues one word request at a time to
// instruction memory over a req/ack handshake and drives the IF/ID register.
// Honours decoder stalls (response parked in a skid buffer) and execute
// redirects (which override stalls and kill in-flight data).
// Parameters:
//   RESET_PC        first fetch address after reset
// Ports:
//   clk             in   rising-edge clock
//   clr_n           in   asynchronous active-low reset
//   bus (master)    stall, redir_en, redir_pc in; imem_req/imem_addr out;
//                   imem_ack/imem_rdata in; instruct/if_pc/if_valid out
//   perf_fetch_cnt  out  IF/ID loads with valid=1          (FETCH_PERF_EN)
//   perf_stall_cnt  out  cycles with stall=1 and if_valid=1 (FETCH_PERF_EN)
// Build option: define FETCH_PERF_EN to add the two performance counters.
// -----------------------------------------------------------------------------
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
   input  logic          clk,
   input  logic          clr_n,
   fetch_stage_if.master bus
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0]   perf_fetch_cnt,
   output logic [31:0]   perf_stall_cnt
`endif
);

   fetch_state_t      r_state;
   fetch_state_t      w_state_next;
   logic [31:0]       r_pc;
   logic [31:0]       r_drain_addr;
   if_id_t            r_if_id;

   logic [31:0]       w_pc_plus;
   logic [31:0]       w_redir_target;
   logic              w_ack_take;
   logic              w_fetch_load;
   logic              w_skid_load;
   logic              w_skid_release;
   logic              w_kill_pending;
   logic [SKID_W-1:0] w_skid_data;
   logic              w_skid_valid;
   logic              w_imem_req;
   logic [31:0]       w_imem_addr;

   assign w_pc_plus      = pc_plus_inc(r_pc);
   assign w_redir_target = align_word(bus.redir_pc);

   // A response is only kept when it answers a live request; in DRAIN, or
   // when a redirect coincides with the ack, the word is dropped.
   assign w_ack_take     = (r_state == REQ) && bus.imem_ack && !bus.redir_en;
   assign w_fetch_load   = w_ack_take && !bus.stall;
   assign w_skid_load    = w_ack_take &&  bus.stall;
   assign w_skid_release = (r_state == HOLD) && !bus.redir_en && !bus.stall;
   // Redirect while a request is unanswered: the memory still owes an ack
   // for the old address, so that address must stay on the bus.
   assign w_kill_pending = (r_state == REQ) && bus.redir_en && !bus.imem_ack;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            w_state_next = REQ;
         end
         REQ: begin
            if (bus.redir_en) begin
               w_state_next = bus.imem_ack ? REQ : DRAIN;
            end else if (bus.imem_ack && bus.stall) begin
               w_state_next = HOLD;
            end
         end
         HOLD: begin
            if (bus.redir_en || !bus.stall) begin
               w_state_next = REQ;
            end
         end
         DRAIN: begin
            if (bus.imem_ack) begin
               w_state_next = REQ;
            end
         end
         default: begin
            w_state_next = IDLE;
         end
      endcase
   end

   always_comb begin
      w_imem_req  = 1'b0;
      w_imem_addr = r_pc;
      case (r_state)
         REQ: begin
            w_imem_req = 1'b1;
         end
         DRAIN: begin
            w_imem_req  = 1'b1;
            w_imem_addr = r_drain_addr;
         end
         default: begin
            w_imem_req = 1'b0;
         end
      endcase
   end

   assign bus.imem_req  = w_imem_req;
   assign bus.imem_addr = w_imem_addr;

   // ---------------------------------------------------------------- PC
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_pc         <= RESET_PC;
         r_drain_addr <= RESET_PC;
      end else begin
         if (bus.redir_en) begin
            r_pc <= w_redir_target;
         end else if (w_ack_take) begin
            r_pc <= w_pc_plus;
         end
         if (w_kill_pending) begin
            r_drain_addr <= r_pc;
         end
      end
   end

   // ---------------------------------------------------------------- skid
   fetch_skid_buf u_skid (
      .clk       (clk),
      .clr_n     (clr_n),
      .i_load    (w_skid_load),
      .i_release (w_skid_release),
      .i_clear   (bus.redir_en),
      .i_data    ({bus.imem_rdata, w_pc_plus}),
      .o_data    (w_skid_data),
      .o_valid   (w_skid_valid)
   );

   // ---------------------------------------------------------------- IF/ID
   // Priority: redirect > stall > new word (memory or skid) > bubble.
   // Every path that drops valid also writes NOP so instruct is 0 when empty.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_if_id <= '0;
      end else if (bus.redir_en) begin
         r_if_id.instr <= NOP_INSTR;
         r_if_id.valid <= 1'b0;
      end else if (!bus.stall) begin
         if (w_fetch_load) begin
            r_if_id.instr <= bus.imem_rdata;
            r_if_id.pc    <= w_pc_plus;
            r_if_id.valid <= 1'b1;
         end else if (w_skid_release && w_skid_valid) begin
            r_if_id.instr <= w_skid_data[63:32];
            r_if_id.pc    <= w_skid_data[31:0];
            r_if_id.valid <= 1'b1;
         end else begin
            r_if_id.instr <= NOP_INSTR;
            r_if_id.valid <= 1'b0;
         end
      end
   end

   assign bus.instruct = r_if_id.instr;
   assign bus.if_pc    = r_if_id.pc;
   assign bus.if_valid = r_if_id.valid;

`ifdef FETCH_PERF_EN
   // ---------------------------------------------------------------- perf
   logic [31:0] r_perf_fetch;
   logic [31:0] r_perf_stall;
   logic        w_ifid_load;

   // Both load sources already exclude redirect and stall.
   assign w_ifid_load = w_fetch_load || (w_skid_release && w_skid_valid);

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         r_perf_fetch <= '0;
         r_perf_stall <= '0;
      end else begin
         if (w_ifid_load) begin
            r_perf_fetch <= r_perf_fetch + 32'd1;
         end
         if (bus.stall && r_if_id.valid) begin
            r_perf_stall <= r_perf_stall + 32'd1;
         end
      end
   end

   assign perf_fetch_cnt = r_perf_fetch;
   assign perf_stall_cnt = r_perf_stall;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Scoreboard bench for fetch_stage. The main sequence pushes hand-computed
// request addresses and IF/ID words into queues; a monitor pops and compares
// whenever the DUT completes a memory handshake or hands a word to the
// decoder (if_valid with no stall). A second instance with RESET_PC at the
// top of the address space covers PC wrap.
// -----------------------------------------------------------------------------
module tb_fetch_stage;
   import fetch_stage_pkg::*;

   typedef struct {
      logic [31:0] instr;
      logic [31:0] pc;
   } ifid_exp_t;

   logic clk;
   logic clr_n;

   int errors = 0;
   int checks = 0;

   logic [31:0] exp_addr[$];
   ifid_exp_t   exp_ifid[$];

   int grant_total = 0;
   int lat         = 0;
   int acks_done;
   int wait_cnt;

   fetch_stage_if bus  ();
   fetch_stage_if bus2 ();

`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch;
   logic [31:0] perf_stall;
   logic [31:0] perf_fetch2;
   logic [31:0] perf_stall2;
`endif

   fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch),
      .perf_stall_cnt (perf_stall)
`endif
   );

   fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk   (clk),
      .clr_n (clr_n),
      .bus   (bus2)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_cnt (perf_fetch2),
      .perf_stall_cnt (perf_stall2)
`endif
   );

   assign bus2.imem_rdata = bus2.imem_addr | 32'h2000_0000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check32(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   // Memory model: acks a live request after 'lat' waiting cycles, as long
   // as the main sequence has granted more acks than were given.
   initial begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
      acks_done      = 0;
      wait_cnt       = 0;
      forever begin
         @(posedge clk);
         #2;
         if (bus.imem_req && (acks_done < grant_total)) begin
            if (wait_cnt >= lat) begin
               bus.imem_ack   = 1'b1;
               bus.imem_rdata = bus.imem_addr | 32'h2000_0000;
               acks_done++;
               wait_cnt = 0;
            end else begin
               bus.imem_ack = 1'b0;
               wait_cnt++;
            end
         end else begin
            bus.imem_ack = 1'b0;
            wait_cnt     = 0;
         end
      end
   end

   // Monitor / scoreboard
   initial begin
      logic [31:0] ea;
      ifid_exp_t   ei;
      forever begin
         @(negedge clk);
         if (clr_n) begin
            if (bus.imem_req && bus.imem_ack) begin
               if (exp_addr.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL req_addr: unexpected handshake at %h, expected none", bus.imem_addr);
               end else begin
                  ea = exp_addr.pop_front();
                  check32("req_addr", bus.imem_addr, ea);
               end
            end
            if (bus.if_valid && !bus.stall) begin
               if (exp_ifid.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL ifid: unexpected word %h pc %h, expected none", bus.instruct, bus.if_pc);
               end else begin
                  ei = exp_ifid.pop_front();
                  check32("ifid_instr", bus.instruct, ei.instr);
                  check32("ifid_pc", bus.if_pc, ei.pc);
               end
            end
            if (!bus.if_valid) begin
               check32("nop_when_invalid", bus.instruct, NOP_INSTR);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of sequence");
      $fatal(1, "watchdog");
   end

   initial begin
      clr_n         = 1'b0;
      bus.stall     = 1'b0;
      bus.redir_en  = 1'b0;
      bus.redir_pc  = 32'h0;
      bus2.stall    = 1'b0;
      bus2.redir_en = 1'b0;
      bus2.redir_pc = 32'h0;
      bus2.imem_ack = 1'b0;

      // ---- reset values
      sample();
      check32("rst_req", {31'b0, bus.imem_req}, 32'h0);
      check32("rst_addr", bus.imem_addr, 32'h0);
      check32("rst_instruct", bus.instruct, 32'h0);
      check32("rst_if_pc", bus.if_pc, 32'h0);
      check32("rst_if_valid", {31'b0, bus.if_valid}, 32'h0);
      check32("rst_state", 32'(dut.r_state), 32'(IDLE));
      check32("rst_addr2", bus2.imem_addr, 32'hFFFF_FFFC);

      // ---- sequential fetch, single-cycle memory
      exp_addr.push_back(32'h0);
      exp_addr.push_back(32'h4);
      exp_addr.push_back(32'h8);
      exp_ifid.push_back('{32'h2000_0000, 32'h4});
      exp_ifid.push_back('{32'h2000_0004, 32'h8});
      exp_ifid.push_back('{32'h2000_0008, 32'hC});
      grant_total = 3;
      tick();
      clr_n = 1'b1;
      sample();
      check32("req_before_idle_exit", {31'b0, bus.imem_req}, 32'h0);
      tick();
      bus2.imem_ack = 1'b1;
      sample();
      check32("first_req", {31'b0, bus.imem_req}, 32'h1);
      check32("wrap_req0", bus2.imem_addr, 32'hFFFF_FFFC);
      tick();
      sample();
      check32("wrap_instr", bus2.instruct, 32'hFFFF_FFFC);
      check32("wrap_if_pc", bus2.if_pc, 32'h0);
      check32("wrap_req1", bus2.imem_addr, 32'h0);
      tick();
      bus2.imem_ack = 1'b0;
      sample();
      check32("wrap_instr2", bus2.instruct, 32'h2000_0000);
      check32("wrap_if_pc2", bus2.if_pc, 32'h4);
`ifdef FETCH_PERF_EN
      check32("perf_fetch2", perf_fetch2, 32'd2);
`endif
      repeat (4) tick();

      // ---- 3-cycle ack latency
      exp_addr.push_back(32'hC);
      exp_addr.push_back(32'h10);
      exp_ifid.push_back('{32'h2000_000C, 32'h10});
      exp_ifid.push_back('{32'h2000_0010, 32'h14});
      tick();
      lat = 2;
      grant_total += 2;
      for (int i = 0; i < 3; i++) begin
         sample();
         check32("lat_addr_stable", bus.imem_addr, 32'hC);
         check32("lat_ack", {31'b0, bus.imem_ack}, (i == 2) ? 32'h1 : 32'h0);
         if (i < 2) tick();
      end
      repeat (6) tick();

      // ---- stall with an ack parked in the skid buffer
      exp_addr.push_back(32'h14);
      exp_addr.push_back(32'h18);
      exp_ifid.push_back('{32'h2000_0014, 32'h18});
      exp_ifid.push_back('{32'h2000_0018, 32'h1C});
      tick();
      lat = 0;
      grant_total += 2;
      tick();
      bus.stall = 1'b1;
      sample();
      check32("stall_ifid_instr", bus.instruct, 32'h2000_0014);
      for (int i = 0; i < 3; i++) begin
         tick();
         sample();
         check32("hold_state", 32'(dut.r_state), 32'(HOLD));
         check32("hold_req", {31'b0, bus.imem_req}, 32'h0);
         check32("hold_ifid_instr", bus.instruct, 32'h2000_0014);
         check32("hold_ifid_pc", bus.if_pc, 32'h18);
      end
      tick();
      bus.stall = 1'b0;
      sample();
      check32("release_pending_state", 32'(dut.r_state), 32'(HOLD));
      tick();
      sample();
      check32("release_state", 32'(dut.r_state), 32'(REQ));
      check32("release_req", {31'b0, bus.imem_req}, 32'h1);
      check32("release_addr", bus.imem_addr, 32'h1C);

      // ---- redirect with an outstanding request (low bits ignored)
      tick();
      bus.redir_en = 1'b1;
      bus.redir_pc = 32'h0000_0103;
      tick();
      bus.redir_en = 1'b0;
      lat = 1;
      grant_total += 1;
      exp_addr.push_back(32'h1C);
      sample();
      check32("drain_state", 32'(dut.r_state), 32'(DRAIN));
      check32("drain_addr", bus.imem_addr, 32'h1C);
      check32("drain_valid", {31'b0, bus.if_valid}, 32'h0);
      tick();
      sample();
      check32("drain_addr_ack", bus.imem_addr, 32'h1C);
      tick();
      sample();
      check32("post_drain_state", 32'(dut.r_state), 32'(REQ));
      check32("post_drain_addr", bus.imem_addr, 32'h100);
      check32("post_drain_valid", {31'b0, bus.if_valid}, 32'h0);

      // ---- redirect coinciding with an ack
      exp_addr.push_back(32'h100);
      tick();
      lat = 0;
      grant_total += 1;
      bus.redir_en = 1'b1;
      bus.redir_pc = 32'h0000_0200;
      tick();
      bus.redir_en = 1'b0;
      sample();
      check32("same_cycle_state", 32'(dut.r_state), 32'(REQ));
      check32("same_cycle_addr", bus.imem_addr, 32'h200);
      check32("same_cycle_valid", {31'b0, bus.if_valid}, 32'h0);

      // ---- redirect during stall with a full skid buffer
      exp_addr.push_back(32'h200);
      exp_addr.push_back(32'h204);
      tick();
      grant_total += 2;
      tick();
      bus.stall = 1'b1;
      sample();
      check32("pre_redir_instr", bus.instruct, 32'h2000_0200);
      tick();
      bus.redir_en = 1'b1;
      bus.redir_pc = 32'h0000_0300;
      sample();
      check32("skid_full_state", 32'(dut.r_state), 32'(HOLD));
      check32("skid_full", {31'b0, dut.u_skid.o_valid}, 32'h1);
      tick();
      bus.redir_en = 1'b0;
      sample();
      check32("redir_stall_valid", {31'b0, bus.if_valid}, 32'h0);
      check32("redir_stall_instr", bus.instruct, 32'h0);
      check32("redir_stall_skid", {31'b0, dut.u_skid.o_valid}, 32'h0);
      check32("redir_stall_state", 32'(dut.r_state), 32'(REQ));
      check32("redir_stall_addr", bus.imem_addr, 32'h300);
      tick();
      bus.stall = 1'b0;
      exp_addr.push_back(32'h300);
      exp_ifid.push_back('{32'h2000_0300, 32'h304});
      tick();
      grant_total += 1;
      repeat (4) tick();

      // ---- final scoreboard state and async reset mid-request
      sample();
      check32("addr_queue_empty", 32'(exp_addr.size()), 32'h0);
      check32("ifid_queue_empty", 32'(exp_ifid.size()), 32'h0);
      check32("final_req", {31'b0, bus.imem_req}, 32'h1);
      check32("final_addr", bus.imem_addr, 32'h304);
`ifdef FETCH_PERF_EN
      check32("perf_fetch", perf_fetch, 32'd9);
      check32("perf_stall", perf_stall, 32'd6);
`endif
      tick();
      lat = 5;
      grant_total += 1;
      tick();
      clr_n = 1'b0;
      #1;
      check32("async_rst_state", 32'(dut.r_state), 32'(IDLE));
      check32("async_rst_req", {31'b0, bus.imem_req}, 32'h0);
      check32("async_rst_addr", bus.imem_addr, 32'h0);
      check32("async_rst_valid", {31'b0, bus.if_valid}, 32'h0);
      check32("async_rst_if_pc", bus.if_pc, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
